// File: rtl/pipeFlow_pkg.sv
// Shared pipeline parameters and lane data type for the beat packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeFlow_pkg;

  // Width of one beat coming out of the upstream pipeline.
  localparam int PF_DATA_W = 5;
  // Beats gathered into one output word.
  localparam int PF_PACK_N = 4;

  // One lane of an output word at the default beat width.
  typedef logic [PF_DATA_W-1:0] lane_t;

endpackage : pipeFlow_pkg

// File: rtl/pipe_packer.sv
// Packs DATA_W-bit beats into DATA_W*PACK_N-bit words; flush emits a partial word.
// Latency: the completing beat (or honoured flush) in cycle N gives out_valid in cycle N+1.
// Backpressure: in_rdy = !out_valid || out_rdy; a held word stalls input and flush.
module pipe_packer
  import pipeFlow_pkg::*;
#(
  parameter int DATA_W = PF_DATA_W,
  parameter int PACK_N = PF_PACK_N
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [DATA_W-1:0]        in_val,
  input  logic                     in_valid,
  output logic                     in_rdy,
  input  logic                     flush_i,
  output logic [DATA_W*PACK_N-1:0] out_word,
  output logic [3:0]               out_count,
  output logic                     out_valid,
  input  logic                     out_rdy
);

  localparam int CNT_W = (PACK_N > 2) ? $clog2(PACK_N) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_N - 1);

  logic [DATA_W-1:0]        lanes [PACK_N];
  logic [CNT_W-1:0]         cnt;
  logic                     acc;
  logic                     flush_ok;
  logic                     emit;
  logic [DATA_W*PACK_N-1:0] nxt_word;
  logic [3:0]               nxt_count;

  // The output register can take a new word whenever it is empty or being drained.
  assign in_rdy    = !out_valid || out_rdy;
  assign acc       = in_valid && in_rdy;
  assign flush_ok  = flush_i && in_rdy;
  // A word leaves on the last lane, or on a flush that has at least one beat to send.
  assign emit      = (acc && (cnt == LAST_LANE)) || (flush_ok && (acc || (cnt != '0)));
  assign nxt_count = 4'(cnt) + 4'(acc);

  // Assemble the candidate word: stored lanes, plus this cycle's beat, zeros above.
  always_comb begin
    nxt_word = '0;
    for (int i = 0; i < PACK_N; i++) begin
      if (i < int'(cnt)) begin
        nxt_word[i*DATA_W +: DATA_W] = lanes[i];
      end else if (acc && (i == int'(cnt))) begin
        nxt_word[i*DATA_W +: DATA_W] = in_val;
      end
    end
  end

  // Lane storage and fill counter; everything is cleared once a word is emitted.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
      for (int i = 0; i < PACK_N; i++) begin
        lanes[i] <= '0;
      end
    end else if (emit) begin
      cnt <= '0;
      for (int i = 0; i < PACK_N; i++) begin
        lanes[i] <= '0;
      end
    end else if (acc) begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < PACK_N; i++) begin
        if (i == int'(cnt)) begin
          lanes[i] <= in_val;
        end
      end
    end
  end

  // Output register: load on emit (only possible when free), drop valid when drained.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_word  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out_word  <= nxt_word;
      out_count <= nxt_count;
      out_valid <= 1'b1;
    end else if (out_valid && out_rdy) begin
      out_valid <= 1'b0;
    end
  end

endmodule : pipe_packer

// File: tb/tb_pipe_packer.sv
// Directed bench for pipe_packer at DATA_W=5, PACK_N=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected words are hand-packed with lane 0 in the low 5 bits.
module tb_pipe_packer;
  import pipeFlow_pkg::*;

  logic        clk_i;
  logic        reset_i;
  logic [4:0]  in_val;
  logic        in_valid;
  logic        in_rdy;
  logic        flush_i;
  logic [19:0] out_word;
  logic [3:0]  out_count;
  logic        out_valid;
  logic        out_rdy;

  int errors;
  int checks;

  pipe_packer #(.DATA_W(5), .PACK_N(4)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .in_val   (in_val),
    .in_valid (in_valid),
    .in_rdy   (in_rdy),
    .flush_i  (flush_i),
    .out_word (out_word),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_rdy  (out_rdy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One cycle with a beat (and optional flush), then inputs return idle.
  task automatic beat(input logic [4:0] v, input logic fl);
    in_val   = v;
    in_valid = 1'b1;
    flush_i  = fl;
    step();
    in_valid = 1'b0;
    flush_i  = 1'b0;
  endtask

  task automatic flush_only();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [19:0] w, input logic [3:0] c);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"}, 32'(out_word), 32'(w));
    chk({tag, "_cnt"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    logic [19:0] held;
    int words;
    errors   = 0;
    checks   = 0;
    reset_i  = 1'b0;
    in_val   = '0;
    in_valid = 1'b0;
    flush_i  = 1'b0;
    out_rdy  = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_rdy", 32'(in_rdy), 32'd1);
    reset_i = 1'b1;
    step();

    // Full word 1,2,3,4
    beat(5'd1, 1'b0);
    beat(5'd2, 1'b0);
    beat(5'd3, 1'b0);
    chk("full_notyet", 32'(out_valid), 32'd0);
    beat(5'd4, 1'b0);
    chk_word("full", 20'h20C41, 4'd4);
    step();
    chk("full_onecyc", 32'(out_valid), 32'd0);

    // Partial by flush alone, then next beat lands in lane 0
    beat(5'd7, 1'b0);
    beat(5'd9, 1'b0);
    flush_only();
    chk_word("flush2", 20'h00127, 4'd2);
    beat(5'd5, 1'b0);
    chk("flush2_drop", 32'(out_valid), 32'd0);
    flush_only();
    chk_word("lane0", 20'h00005, 4'd1);
    // Flush with nothing stored emits nothing
    flush_only();
    chk("empty_flush", 32'(out_valid), 32'd0);

    // Flush coinciding with the last lane, and with a middle lane
    beat(5'd1, 1'b0);
    beat(5'd2, 1'b0);
    beat(5'd3, 1'b0);
    beat(5'd31, 1'b1);
    chk_word("flush_last", 20'hF8C41, 4'd4);
    beat(5'd1, 1'b0);
    beat(5'd2, 1'b0);
    beat(5'd3, 1'b1);
    chk_word("flush_beat3", 20'h00C41, 4'd3);

    // Back-to-back single-lane words: valid never drops
    beat(5'd17, 1'b1);
    chk_word("b2b_a", 20'h00011, 4'd1);
    beat(5'd18, 1'b1);
    chk_word("b2b_b", 20'h00012, 4'd1);
    step();
    chk("b2b_end", 32'(out_valid), 32'd0);

    // Held word stalls input and flush
    out_rdy = 1'b0;
    beat(5'd1, 1'b0);
    beat(5'd2, 1'b0);
    beat(5'd3, 1'b0);
    beat(5'd4, 1'b0);
    held = out_word;
    chk("stall_word0", 32'(held), 32'h20C41);
    in_val   = 5'd9;
    in_valid = 1'b1;
    flush_i  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_rdy", 32'(in_rdy), 32'd0);
      step();
      chk_word("stall", 20'h20C41, 4'd4);
    end
    flush_i = 1'b0;
    out_rdy = 1'b1;
    step();
    chk("stall_release", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    beat(5'd10, 1'b0);
    beat(5'd11, 1'b0);
    beat(5'd12, 1'b0);
    chk_word("stall_next", 20'h62D49, 4'd4);
    step();

    // Continuous stream 0..11
    words = 0;
    for (int i = 0; i < 12; i++) begin
      in_val   = 5'(i);
      in_valid = 1'b1;
      chk("stream_rdy", 32'(in_rdy), 32'd1);
      step();
      chk("stream_vld", 32'(out_valid), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (out_valid) words++;
      if (i == 3)  chk("stream_w0", 32'(out_word), 32'h18820);
      if (i == 7)  chk("stream_w1", 32'(out_word), 32'h398A4);
      if (i == 11) chk("stream_w2", 32'(out_word), 32'h5A928);
    end
    in_valid = 1'b0;
    chk("stream_words", 32'(words), 32'd3);
    step();

    // Reset mid-fill discards the partial word
    beat(5'd1, 1'b0);
    beat(5'd2, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_rdy", 32'(in_rdy), 32'd1);
    step();
    reset_i = 1'b1;
    beat(5'd3, 1'b0);
    beat(5'd4, 1'b0);
    beat(5'd5, 1'b0);
    beat(5'd6, 1'b0);
    chk_word("postrst", 20'h31483, 4'd4);
    step();

    // Reset with a word held clears the output register at once
    out_rdy = 1'b0;
    beat(5'd8, 1'b1);
    chk_word("hold_pre", 20'h00008, 4'd1);
    reset_i = 1'b0;
    #1;
    chk("holdrst_vld", 32'(out_valid), 32'd0);
    chk("holdrst_word", 32'(out_word), 32'd0);
    chk("holdrst_cnt", 32'(out_count), 32'd0);
    step();
    reset_i = 1'b1;
    out_rdy = 1'b1;
    beat(5'd21, 1'b1);
    chk_word("holdrst_lane0", 20'h00015, 4'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_packer
